// File: rtl/dvp_capture_window_pkg.sv
// Shared definitions for the DVP capture front end: FSM encoding and byte-order constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dvp_pkg;

    // Frame-level FSM encoding
    localparam logic [1:0] WAIT_VS = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] SKIP    = 2'd2;

    // CFG_SWAP meaning: which half of the pixel the first bus beat lands in
    localparam logic SWAP_MSB_FIRST = 1'b0;
    localparam logic SWAP_LSB_FIRST = 1'b1;

    // Slice index (0 = least significant) that a given beat fills
    function automatic logic [1:0] beat_slot(input logic       swap,
                                             input logic [1:0] beat,
                                             input logic [1:0] last);
        return (swap == SWAP_LSB_FIRST) ? beat : (last - beat);
    endfunction

endpackage

// File: rtl/dvp_capture_window_if.sv
// Sensor pins, per-frame configuration and pixel/status outputs of the capture front end.
// Latency: n/a (signal bundle only).
// Backpressure: none; the sensor cannot be stalled, consumers must accept every PIX_EN.
interface dvp_capture_window_if #(
    parameter int DIN_W = 8,
    parameter int BPP   = 2,
    parameter int CNT_W = 11
);
    // Sensor side
    logic                   CAM_VSYNC;
    logic                   CAM_HREF;
    logic [DIN_W-1:0]       CAM_D;

    // Configuration
    logic                   CFG_EN;
    logic                   CFG_SWAP;
    logic [CNT_W-1:0]       CFG_X0;
    logic [CNT_W-1:0]       CFG_XS;
    logic [CNT_W-1:0]       CFG_Y0;
    logic [CNT_W-1:0]       CFG_YS;

    // Pixel stream and frame status
    logic [DIN_W*BPP-1:0]   PIX_DATA;
    logic                   PIX_EN;
    logic [CNT_W-1:0]       PIX_X;
    logic [CNT_W-1:0]       PIX_Y;
    logic                   FRAME_START;
    logic                   FRAME_END;
    logic                   FRAME_ERR;
    logic [15:0]            FRAME_CNT;

    // Sensor model / configuration owner
    modport master (
        output CAM_VSYNC, CAM_HREF, CAM_D,
        output CFG_EN, CFG_SWAP, CFG_X0, CFG_XS, CFG_Y0, CFG_YS,
        input  PIX_DATA, PIX_EN, PIX_X, PIX_Y,
        input  FRAME_START, FRAME_END, FRAME_ERR, FRAME_CNT
    );

    // Capture block
    modport slave (
        input  CAM_VSYNC, CAM_HREF, CAM_D,
        input  CFG_EN, CFG_SWAP, CFG_X0, CFG_XS, CFG_Y0, CFG_YS,
        output PIX_DATA, PIX_EN, PIX_X, PIX_Y,
        output FRAME_START, FRAME_END, FRAME_ERR, FRAME_CNT
    );

endinterface

// File: rtl/dvp_capture_window_sync_edge.sv
// One-stage input register with rise/fall detection against a delayed copy.
// Latency: q one clock after d; edge flags valid in the cycle q changes.
// Backpressure: none; edges are suppressed until two real samples exist after reset.
module dvp_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] q_r;
    logic [W-1:0] q_d;
    logic [1:0]   primed;

    // Sample the pin, keep one delayed copy, and track when both hold real data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            q_d    <= '0;
            primed <= 2'b00;
        end else begin
            q_r    <= d;
            q_d    <= q_r;
            primed <= {primed[0], 1'b1};
        end
    end

    // A level already present at reset release is not reported as an edge
    assign q    = q_r;
    assign rise = primed[1] ? ( q_r & ~q_d) : '0;
    assign fall = primed[1] ? (~q_r &  q_d) : '0;

endmodule

// File: rtl/dvp_capture_window.sv
// DVP capture front end: assembles BPP beats per pixel, crops a window, reports per-frame status.
// Latency: PIX_EN two CAM_PCLK edges after the edge that samples the final beat of a pixel.
// Backpressure: none; at most one pixel every BPP cycles, consumer must always accept.
module dvp_capture_window
    import dvp_pkg::*;
#(
    parameter int DIN_W    = 8,
    parameter int BPP      = 2,
    parameter int CNT_W    = 11,
    parameter int H_ACTIVE = 320,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                 CAM_PCLK,
    input  logic                 RST,
    dvp_capture_window_if.slave  bus
);

    localparam int               PIX_W     = DIN_W * BPP;
    localparam logic [1:0]       BEAT_LAST = 2'(BPP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);

    // ---------------------------------------------------------------- input stage
    logic             vs_q, vs_rise, vs_fall;
    logic             href_q, href_rise, href_fall;
    logic [DIN_W-1:0] d_q;

    dvp_sync_edge #(.W(1)) u_vs_sync (
        .clk  (CAM_PCLK),
        .rst  (RST),
        .d    (bus.CAM_VSYNC),
        .q    (vs_q),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    dvp_sync_edge #(.W(1)) u_href_sync (
        .clk  (CAM_PCLK),
        .rst  (RST),
        .d    (bus.CAM_HREF),
        .q    (href_q),
        .rise (href_rise),
        .fall (href_fall)
    );

    // Data bus register, aligned with the VSYNC/HREF input stage
    always_ff @(posedge CAM_PCLK or posedge RST) begin
        if (RST) d_q <= '0;
        else     d_q <= bus.CAM_D;
    end

    // ---------------------------------------------------------------- state
    logic [1:0]       state;
    logic             swap_l;
    logic [CNT_W-1:0] x0_l, xs_l, y0_l, ys_l;
    logic [1:0]       beat;
    logic [CNT_W-1:0] cx, ly;
    logic [PIX_W-1:0] acc;

    logic             s1_vld;
    logic [PIX_W-1:0] s1_dat;
    logic [CNT_W-1:0] s1_cx, s1_ly;

    logic             pix_en_q, frame_start_q, frame_end_q, frame_err_q;
    logic [PIX_W-1:0] pix_data_q;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    logic [15:0]      frame_cnt_q;

    // ---------------------------------------------------------------- decode
    logic             frame_start, frame_end, vs_act, in_cap, capt;
    logic [1:0]       beat_cur, slot;
    logic [CNT_W-1:0] cx_cur;
    logic [PIX_W-1:0] acc_nxt;
    logic             pix_done, line_close, line_err, err_set;

    // Frame edges, line-start normalisation and beat placement
    always_comb begin
        frame_start = VS_POL ? vs_rise : vs_fall;
        frame_end   = VS_POL ? vs_fall : vs_rise;
        vs_act      = (vs_q == VS_POL);
        in_cap      = (state == CAPTURE);
        // Beats are only taken while VSYNC is still active; the frame-end cycle only closes
        capt        = in_cap && vs_act;

        // A fresh HREF rise always starts column/beat at zero, even if a close was missed
        beat_cur    = href_rise ? 2'd0 : beat;
        cx_cur      = href_rise ? '0   : cx;
        slot        = beat_slot(swap_l, beat_cur, BEAT_LAST);

        acc_nxt = acc;
        for (int k = 0; k < BPP; k++) begin
            if (slot == 2'(k)) acc_nxt[k*DIN_W +: DIN_W] = d_q;
        end

        pix_done   = capt && href_q && (beat_cur == BEAT_LAST);
        line_close = in_cap && (href_fall || (frame_end && href_q));
        line_err   = (beat_cur != 2'd0) || (cx_cur != H_ACT_C);
        err_set    = (line_close && line_err) || (pix_done && (cx_cur == CNT_MAX));
    end

    // Frame FSM plus FRAME_START/FRAME_END pulses, sticky error and frame counter
    always_ff @(posedge CAM_PCLK or posedge RST) begin
        if (RST) begin
            state         <= WAIT_VS;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (frame_start) begin
                        if (bus.CFG_EN) begin
                            state         <= CAPTURE;
                            frame_start_q <= 1'b1;
                            frame_err_q   <= 1'b0;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                CAPTURE: begin
                    // Line-close errors on the frame-end cycle still land with FRAME_END
                    frame_err_q <= frame_err_q | err_set;
                    if (frame_end) begin
                        state       <= WAIT_VS;
                        frame_end_q <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                SKIP: begin
                    if (frame_end) state <= WAIT_VS;
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

    // Configuration is frozen for the whole frame at an accepted frame start
    always_ff @(posedge CAM_PCLK or posedge RST) begin
        if (RST) begin
            swap_l <= SWAP_MSB_FIRST;
            x0_l   <= '0;
            xs_l   <= '0;
            y0_l   <= '0;
            ys_l   <= '0;
        end else if ((state == WAIT_VS) && frame_start && bus.CFG_EN) begin
            swap_l <= bus.CFG_SWAP;
            x0_l   <= bus.CFG_X0;
            xs_l   <= bus.CFG_XS;
            y0_l   <= bus.CFG_Y0;
            ys_l   <= bus.CFG_YS;
        end
    end

    // Beat assembly and saturating column/line counters
    always_ff @(posedge CAM_PCLK or posedge RST) begin
        if (RST) begin
            beat <= 2'd0;
            cx   <= '0;
            ly   <= '0;
            acc  <= '0;
        end else if (state == WAIT_VS) begin
            // Held at zero outside a frame so a frame start always begins at line 0, column 0
            beat <= 2'd0;
            cx   <= '0;
            ly   <= '0;
            acc  <= '0;
        end else if (line_close) begin
            // Any partially assembled pixel is dropped here
            beat <= 2'd0;
            cx   <= '0;
            if (ly != CNT_MAX) ly <= ly + CNT_ONE;
        end else if (capt && href_q) begin
            acc <= acc_nxt;
            if (beat_cur == BEAT_LAST) begin
                beat <= 2'd0;
                cx   <= (cx_cur == CNT_MAX) ? cx_cur : (cx_cur + CNT_ONE);
            end else begin
                beat <= beat_cur + 2'd1;
                cx   <= cx_cur;
            end
        end
    end

    // Completed input pixel with its input coordinates
    always_ff @(posedge CAM_PCLK or posedge RST) begin
        if (RST) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_cx  <= '0;
            s1_ly  <= '0;
        end else begin
            s1_vld <= pix_done;
            if (pix_done) begin
                s1_dat <= acc_nxt;
                s1_cx  <= cx_cur;
                s1_ly  <= ly;
            end
        end
    end

    // Window compare one bit wider than the counters so X0+XS cannot wrap
    logic [CNT_W:0] cx_e, x_lo, x_hi, ly_e, y_lo, y_hi;
    logic           in_win;

    always_comb begin
        cx_e   = {1'b0, s1_cx};
        x_lo   = {1'b0, x0_l};
        x_hi   = {1'b0, x0_l} + {1'b0, xs_l};
        ly_e   = {1'b0, s1_ly};
        y_lo   = {1'b0, y0_l};
        y_hi   = {1'b0, y0_l} + {1'b0, ys_l};
        in_win = (cx_e >= x_lo) && (cx_e < x_hi) && (ly_e >= y_lo) && (ly_e < y_hi);
    end

    // Output register: window-relative coordinates, data held between pixels
    always_ff @(posedge CAM_PCLK or posedge RST) begin
        if (RST) begin
            pix_en_q   <= 1'b0;
            pix_data_q <= '0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
        end else begin
            pix_en_q <= s1_vld && in_win;
            if (s1_vld && in_win) begin
                pix_data_q <= s1_dat;
                pix_x_q    <= s1_cx - x0_l;
                pix_y_q    <= s1_ly - y0_l;
            end
        end
    end

    assign bus.PIX_EN      = pix_en_q;
    assign bus.PIX_DATA    = pix_data_q;
    assign bus.PIX_X       = pix_x_q;
    assign bus.PIX_Y       = pix_y_q;
    assign bus.FRAME_START = frame_start_q;
    assign bus.FRAME_END   = frame_end_q;
    assign bus.FRAME_ERR   = frame_err_q;
    assign bus.FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_dvp_capture_window.sv
// Directed bench for the DVP capture front end with hand-computed expectations.
// Latency: checks the two-edge pixel latency explicitly.
// Backpressure: none; every PIX_EN is counted by a free-running monitor.
`timescale 1ns/1ps
module tb_dvp_capture_window;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dvp_capture_window_if #(.DIN_W(8), .BPP(2), .CNT_W(11)) bus ();

    dvp_capture_window #(
        .DIN_W(8), .BPP(2), .CNT_W(11), .H_ACTIVE(320), .VS_POL(1'b1)
    ) dut (
        .CAM_PCLK (clk),
        .RST      (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, sampled on the falling edge away from DUT updates
    int          pix_total = 0;
    int          fs_total  = 0;
    int          fe_total  = 0;
    int          frame_pix = 0;
    logic [15:0] first_data, last_data, cnt_at_fe;
    logic [10:0] first_x, first_y, last_x, last_y;
    logic        err_at_fe;

    always @(negedge clk) begin
        if (bus.FRAME_START) begin
            fs_total  <= fs_total + 1;
            frame_pix <= 0;
        end
        if (bus.PIX_EN) begin
            pix_total <= pix_total + 1;
            frame_pix <= frame_pix + 1;
            if (frame_pix == 0) begin
                first_data <= bus.PIX_DATA;
                first_x    <= bus.PIX_X;
                first_y    <= bus.PIX_Y;
            end
            last_data <= bus.PIX_DATA;
            last_x    <= bus.PIX_X;
            last_y    <= bus.PIX_Y;
        end
        if (bus.FRAME_END) begin
            fe_total  <= fe_total + 1;
            err_at_fe <= bus.FRAME_ERR;
            cnt_at_fe <= bus.FRAME_CNT;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic en, input logic swap, input int x0, input int xs,
                           input int y0, input int ys);
        bus.CFG_EN   = en;
        bus.CFG_SWAP = swap;
        bus.CFG_X0   = 11'(x0);
        bus.CFG_XS   = 11'(xs);
        bus.CFG_Y0   = 11'(y0);
        bus.CFG_YS   = 11'(ys);
    endtask

    task automatic frame_begin();
        bus.CAM_VSYNC = 1'b1;
        tick(4);
    endtask

    task automatic frame_finish();
        bus.CAM_VSYNC = 1'b0;
        tick(6);
    endtask

    // Beats carry the low byte of their index within the line
    task automatic beats(input int first, input int n);
        bus.CAM_HREF = 1'b1;
        for (int i = first; i < first + n; i++) begin
            bus.CAM_D = i[7:0];
            @(negedge clk);
        end
    endtask

    task automatic line_end();
        bus.CAM_HREF = 1'b0;
        bus.CAM_D    = 8'h00;
        tick(6);
    endtask

    task automatic send_line(input int n);
        beats(0, n);
        line_end();
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++; if (bus.PIX_EN !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en: got %b want 0", bus.PIX_EN); end
        n_checks++; if (bus.PIX_DATA !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h want 0000", bus.PIX_DATA); end
        n_checks++; if (bus.FRAME_START !== 1'b0 || bus.FRAME_END !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", bus.FRAME_START, bus.FRAME_END); end
        n_checks++; if (bus.FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", bus.FRAME_ERR); end
        n_checks++; if (bus.FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.FRAME_CNT); end
        rst = 1'b0;
        tick(4);
    endtask

    // Full-width lines through the default window (24 lines to keep the run short)
    task automatic test_full_frame();
        int p0, fs0, fe0;
        p0 = pix_total; fs0 = fs_total; fe0 = fe_total;
        set_cfg(1'b1, 1'b0, 0, 320, 0, 240);
        frame_begin();
        for (int l = 0; l < 24; l++) send_line(640);
        frame_finish();
        n_checks++; if (pix_total - p0 !== 7680) begin n_fail++; $display("FAIL full_pix_count: got %0d want 7680", pix_total - p0); end
        n_checks++; if (last_x !== 11'd319 || last_y !== 11'd23) begin n_fail++; $display("FAIL full_last_xy: got %0d,%0d want 319,23", last_x, last_y); end
        n_checks++; if (last_data !== 16'h7E7F) begin n_fail++; $display("FAIL full_last_data: got %h want 7e7f", last_data); end
        n_checks++; if (fs_total - fs0 !== 1 || fe_total - fe0 !== 1) begin n_fail++; $display("FAIL full_pulses: got fs %0d fe %0d want 1 1", fs_total - fs0, fe_total - fe0); end
        n_checks++; if (err_at_fe !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b want 0", err_at_fe); end
        n_checks++; if (cnt_at_fe !== 16'd1 || bus.FRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL full_cnt: got %0d/%0d want 1", cnt_at_fe, bus.FRAME_CNT); end
    endtask

    // Byte order and exact two-edge latency after the final beat is sampled
    task automatic test_swap_latency();
        logic [15:0] want;
        for (int s = 0; s < 2; s++) begin
            want = (s == 1) ? 16'hCDAB : 16'hABCD;
            set_cfg(1'b1, s[0], 0, 320, 0, 240);
            frame_begin();
            bus.CAM_HREF = 1'b1;
            bus.CAM_D    = 8'hAB;
            @(negedge clk);
            bus.CAM_D    = 8'hCD;
            @(posedge clk);           // this edge samples 0xCD
            #1;
            @(posedge clk); #1;
            n_checks++; if (bus.PIX_EN !== 1'b0) begin n_fail++; $display("FAIL latency_early swap=%0d: got %b want 0", s, bus.PIX_EN); end
            @(posedge clk); #1;
            n_checks++; if (bus.PIX_EN !== 1'b1) begin n_fail++; $display("FAIL latency_on_time swap=%0d: got %b want 1", s, bus.PIX_EN); end
            n_checks++; if (bus.PIX_DATA !== want) begin n_fail++; $display("FAIL swap_data swap=%0d: got %h want %h", s, bus.PIX_DATA, want); end
            @(negedge clk);
            line_end();
            frame_finish();
        end
    endtask

    task automatic test_window();
        int p0;
        p0 = pix_total;
        set_cfg(1'b1, 1'b0, 10, 4, 2, 3);
        frame_begin();
        for (int l = 0; l < 6; l++) send_line(640);
        frame_finish();
        n_checks++; if (pix_total - p0 !== 12) begin n_fail++; $display("FAIL win_count: got %0d want 12", pix_total - p0); end
        n_checks++; if (first_x !== 11'd0 || first_y !== 11'd0) begin n_fail++; $display("FAIL win_first_xy: got %0d,%0d want 0,0", first_x, first_y); end
        n_checks++; if (first_data !== 16'h1415) begin n_fail++; $display("FAIL win_first_data: got %h want 1415", first_data); end
        n_checks++; if (last_x !== 11'd3 || last_y !== 11'd2) begin n_fail++; $display("FAIL win_last_xy: got %0d,%0d want 3,2", last_x, last_y); end
        n_checks++; if (last_data !== 16'h1A1B) begin n_fail++; $display("FAIL win_last_data: got %h want 1a1b", last_data); end
        n_checks++; if (err_at_fe !== 1'b0) begin n_fail++; $display("FAIL win_err: got %b want 0", err_at_fe); end
    endtask

    task automatic test_short_line();
        int p0;
        p0 = pix_total;
        set_cfg(1'b1, 1'b0, 0, 320, 0, 240);
        frame_begin();
        send_line(640);
        send_line(639);
        send_line(640);
        frame_finish();
        n_checks++; if (pix_total - p0 !== 959) begin n_fail++; $display("FAIL short_count: got %0d want 959", pix_total - p0); end
        n_checks++; if (err_at_fe !== 1'b1) begin n_fail++; $display("FAIL short_err_at_end: got %b want 1", err_at_fe); end
        n_checks++; if (bus.FRAME_ERR !== 1'b1) begin n_fail++; $display("FAIL short_err_held: got %b want 1", bus.FRAME_ERR); end
        frame_begin();
        n_checks++; if (bus.FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL short_err_cleared: got %b want 0", bus.FRAME_ERR); end
        send_line(640);
        frame_finish();
        n_checks++; if (err_at_fe !== 1'b0) begin n_fail++; $display("FAIL short_next_err: got %b want 0", err_at_fe); end
    endtask

    task automatic test_disabled();
        int p0, fs0, fe0;
        logic [15:0] c0;
        p0 = pix_total; fs0 = fs_total; fe0 = fe_total; c0 = bus.FRAME_CNT;
        set_cfg(1'b0, 1'b0, 0, 320, 0, 240);
        frame_begin();
        bus.CFG_EN = 1'b1;
        send_line(640);
        send_line(640);
        frame_finish();
        n_checks++; if (pix_total - p0 !== 0) begin n_fail++; $display("FAIL skip_pix: got %0d want 0", pix_total - p0); end
        n_checks++; if (fs_total - fs0 !== 0 || fe_total - fe0 !== 0) begin n_fail++; $display("FAIL skip_pulses: got fs %0d fe %0d want 0 0", fs_total - fs0, fe_total - fe0); end
        n_checks++; if (bus.FRAME_CNT !== c0) begin n_fail++; $display("FAIL skip_cnt: got %0d want %0d", bus.FRAME_CNT, c0); end
        frame_begin();
        send_line(640);
        frame_finish();
        n_checks++; if (pix_total - p0 !== 320) begin n_fail++; $display("FAIL after_skip_pix: got %0d want 320", pix_total - p0); end
        n_checks++; if (bus.FRAME_CNT !== c0 + 16'd1) begin n_fail++; $display("FAIL after_skip_cnt: got %0d want %0d", bus.FRAME_CNT, c0 + 16'd1); end
    endtask

    task automatic test_mid_reset();
        int p0, fs0, fe0;
        set_cfg(1'b1, 1'b0, 0, 320, 0, 240);
        frame_begin();
        beats(0, 101);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.PIX_EN !== 1'b0 || bus.PIX_DATA !== 16'h0) begin n_fail++; $display("FAIL rst_pix: got en %b data %h want 0 0000", bus.PIX_EN, bus.PIX_DATA); end
        n_checks++; if (bus.PIX_X !== 11'd0) begin n_fail++; $display("FAIL rst_pix_x: got %0d want 0", bus.PIX_X); end
        n_checks++; if (bus.FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", bus.FRAME_CNT); end
        p0 = pix_total; fs0 = fs_total; fe0 = fe_total;
        @(negedge clk);
        beats(101, 2);
        rst = 1'b0;
        beats(103, 537);
        line_end();
        send_line(640);
        frame_finish();
        n_checks++; if (pix_total - p0 !== 0 || fs_total - fs0 !== 0 || fe_total - fe0 !== 0) begin n_fail++; $display("FAIL rst_skip: got pix %0d fs %0d fe %0d want 0 0 0", pix_total - p0, fs_total - fs0, fe_total - fe0); end
        n_checks++; if (bus.FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL rst_cnt_after: got %0d want 0", bus.FRAME_CNT); end
        frame_begin();
        send_line(640);
        send_line(640);
        frame_finish();
        n_checks++; if (bus.FRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL rst_next_cnt: got %0d want 1", bus.FRAME_CNT); end
        n_checks++; if (pix_total - p0 !== 640 || err_at_fe !== 1'b0) begin n_fail++; $display("FAIL rst_next_frame: got pix %0d err %b want 640 0", pix_total - p0, err_at_fe); end
    endtask

    initial begin
        bus.CAM_VSYNC = 1'b0;
        bus.CAM_HREF  = 1'b0;
        bus.CAM_D     = 8'h00;
        set_cfg(1'b0, 1'b0, 0, 0, 0, 0);
        test_reset();
        test_full_frame();
        test_swap_latency();
        test_window();
        test_short_line();
        test_disabled();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
